// File: rtl/gpu_pkg.sv
// Shared types and default widths for the core front-end blocks.
package gpu_pkg;

  localparam int DEFAULT_ADDRESS_BITS = 8;
  localparam int DEFAULT_INSTR_BITS   = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT     = 2'd1,
    FETCHING = 2'd2,
    DISCARD  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry FIFO of {pc, instr} pairs; flush beats push/pop, empty pops are no-ops.
// Head is a combinational read of the entry at rd_ptr.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] entries_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != FULL_CNT) || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only observable once counted.
  always_ff @(posedge clk) begin
    if (do_push && !flush) entries_q[wr_ptr_q] <= push_data;
  end

  assign head  = entries_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/prefetch_fetcher.sv
// Sequential instruction prefetcher: FSM, fetch PC and program-memory request port
// in front of a small {pc, instr} queue; redirects flush and drop stale responses.
module prefetch_fetcher
  import gpu_pkg::*;
#(
  parameter int ADDRESS_BITS = DEFAULT_ADDRESS_BITS,
  parameter int INSTR_BITS   = DEFAULT_INSTR_BITS,
  parameter int DEPTH        = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    redirect_valid,
  input  logic [ADDRESS_BITS-1:0] redirect_pc,
  input  logic                    halt,
  output logic                    instr_valid,
  output logic [INSTR_BITS-1:0]   instr_data,
  output logic [ADDRESS_BITS-1:0] instr_pc,
  input  logic                    instr_ready,
  output logic                    mem_read_valid,
  output logic [ADDRESS_BITS-1:0] mem_read_address,
  input  logic                    mem_read_ready,
  input  logic [INSTR_BITS-1:0]   mem_read_data,
  output logic                    busy
);

  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int ENTRY_W = ADDRESS_BITS + INSTR_BITS;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fetch_state_e            state_q, state_d;
  logic [ADDRESS_BITS-1:0] fetch_pc_q, fetch_pc_d;
  logic                    mem_vld_q, mem_vld_d;
  logic [ADDRESS_BITS-1:0] mem_addr_q, mem_addr_d;

  logic                    q_push, q_pop, q_flush;
  logic [ENTRY_W-1:0]      q_head;
  logic [CNT_W-1:0]        q_count;
  logic                    outstanding;

  assign instr_valid = (q_count != '0);
  assign outstanding = (state_q == FETCHING) || (state_q == DISCARD);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_vld_d  = mem_vld_q;
    mem_addr_d = mem_addr_q;
    q_push     = 1'b0;
    q_flush    = 1'b0;
    q_pop      = instr_valid && instr_ready && !redirect_valid;

    if (redirect_valid) begin
      q_flush    = 1'b1;
      fetch_pc_d = redirect_pc;
      // A response landing with the redirect closes the old request, so the
      // next request on the bus is already the redirect target.
      if (outstanding && !mem_read_ready) begin
        state_d = DISCARD;
      end else begin
        state_d   = WAIT;
        mem_vld_d = 1'b0;
      end
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        WAIT: begin
          if (halt) begin
            state_d = IDLE;
          end else if (q_count != FULL_CNT) begin
            mem_vld_d  = 1'b1;
            mem_addr_d = fetch_pc_q;
            state_d    = FETCHING;
          end
        end
        FETCHING: begin
          if (mem_read_ready) begin
            q_push     = 1'b1;
            fetch_pc_d = fetch_pc_q + ADDRESS_BITS'(1);
            mem_vld_d  = 1'b0;
            state_d    = halt ? IDLE : WAIT;
          end
        end
        DISCARD: begin
          if (mem_read_ready) begin
            mem_vld_d = 1'b0;
            state_d   = halt ? IDLE : WAIT;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= '0;
      mem_vld_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_vld_q  <= mem_vld_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (q_flush),
    .push      (q_push),
    .push_data ({mem_addr_q, mem_read_data}),
    .pop       (q_pop),
    .head      (q_head),
    .count     (q_count)
  );

  assign instr_pc         = instr_valid ? q_head[ENTRY_W-1:INSTR_BITS] : '0;
  assign instr_data       = instr_valid ? q_head[INSTR_BITS-1:0] : '0;
  assign mem_read_valid   = mem_vld_q;
  assign mem_read_address = mem_addr_q;
  assign busy             = (state_q != IDLE);

endmodule
